conv_out_packer: RTL and testbench
==================================

# conv_out_packer

Downstream stage of the convolutional encoder. Takes the encoder's 3-bit parallel output (one bit per subblock stream d0/d1/d2 per input bit), packs each stream into bytes, and writes them to the output FIFO interleaved as stream 0, 1, 2 per byte group. A 2-group buffer absorbs output-FIFO backpressure and stalls the encoder when exhausted.

## Interface
Parameters:
- GRP_DEPTH, 2: group buffer depth in 3-byte groups; only 2 is supported.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enc_valid  in  1  enc_d carries a valid 3-bit sample
- enc_d  in  3  bit i = next bit of stream di
- enc_last  in  1  qualifies enc_valid; the sample is the last of the code block
- enc_stall  out  1  upstream must hold enc_d; sample not accepted
- out_full  in  1  output FIFO full
- out_wrreq  out  1  output FIFO write strobe
- out_data  out  8  packed byte
- out_stream  out  2  stream index of out_data (0,1,2)
- out_last  out  1  with out_wrreq: final byte of the block (stream 2 of last group)
- blk_done  out  1  one-cycle pulse, cycle after out_last write

## Operation
- Accept: sample accepted when enc_valid && !enc_stall. enc_stall = (group count == 2), purely from current count.
- Packing: bit counter bcnt[2:0], three byte registers sr0..sr2. On accept, enc_d[i] written into sr_i at position (7-bcnt); bcnt++. sr_i cleared when a group starts (bcnt==0 accept overwrites with zeros elsewhere).
- Group completes on accepting with bcnt==7 or enc_last==1. Group {sr0, sr1, sr2, last} pushed to buffer; bcnt -> 0. Partial group (enc_last, bcnt<7) padded with zeros in unwritten low positions.
- Buffer: 2-entry FIFO of groups, count 0..2. Push and pop in the same cycle allowed (count unchanged).
- Emit FSM states IDLE, E0, E1, E2:
  - IDLE: count!=0 -> E0 next cycle.
  - Ek: out_wrreq = !out_full; out_data = head byte k, out_stream = k. If written, advance Ek -> E(k+1); else hold.
  - E2 written: pop head; out_last = head.last; next state E0 if count after pop !=0, else IDLE.
- blk_done registered from (E2 write && head.last).
- out_wrreq, out_data, out_stream, out_last combinational from state, head and out_full; out_data=0, out_stream=0 when not writing.

## Timing
- Reset values: state IDLE, count 0, bcnt 0, sr* 0, enc_stall 0, out_wrreq 0, out_data 0, out_stream 0, out_last 0, blk_done 0.
- Latency: completing bit accepted in cycle N -> stream-0 byte written in cycle N+2, streams 1,2 in N+3, N+4 with out_full low.
- Throughput: 3 bytes per 8 samples; continuous enc_valid never stalls if out_full stays low.
- out_full high during Ek: no write, state and data held; write resumes the cycle out_full drops.
- Buffer full (count 2): enc_stall high same cycle; input sample held by upstream, not lost, not duplicated.
- enc_last with bcnt==0: single-bit group, bytes 0x80/0x00 pattern per stream.
- Back-to-back blocks: next block's first sample may be accepted the cycle after the previous enc_last; bcnt restarts at 0.
- Reset mid-block: partial group and buffered groups discarded, no out_last/blk_done emitted.

## Configuration
- PACK_MSB_FIRST_EN defined: first bit of each byte placed at bit 7 (position 7-bcnt), padding in low bits.
- Undefined: LSB-first; bit placed at position bcnt, padding in high bits. All else identical.

## Test plan
- 40-bit block, all enc_d=3'b101, out_full low -> 15 writes, streams 0,1,2 repeating, data 0xFF,0x00,0xFF, out_last on write 15, blk_done next cycle.
- Single sample enc_d=3'b011 with enc_last (MSB-first) -> bytes 0x80,0x80,0x00, out_last on third write.
- out_full held high 30 cycles during 64-bit block -> enc_stall asserts once 2 groups buffered, no writes; on release all 24 bytes emerge in order, no loss/duplication.
- 12-bit block, bit pattern 1,0,1,... on stream 0 -> stream-0 bytes 0xAA, 0xA0 (MSB-first); 0x55, 0x05 without PACK_MSB_FIRST_EN.
- Reset asserted mid-E1 of a 48-bit block -> outputs zero next cycle, no further writes; following 8-bit block packs from bcnt 0 correctly.
- out_full toggling each cycle during continuous input -> byte order exact, count never exceeds 2.

Source files
------------

// File: rtl/conv_out_packer_if.sv
// Encoder-sample input and output-FIFO write bus for conv_out_packer.
// The master modport is the packer side, the slave modport is its environment.
interface conv_out_packer_if;
   logic       enc_valid;
   logic [2:0] enc_d;
   logic       enc_last;
   logic       enc_stall;
   logic       out_full;
   logic       out_wrreq;
   logic [7:0] out_data;
   logic [1:0] out_stream;
   logic       out_last;
   logic       blk_done;

   modport master (
      input  enc_valid, enc_d, enc_last, out_full,
      output enc_stall, out_wrreq, out_data, out_stream, out_last, blk_done
   );

   modport slave (
      output enc_valid, enc_d, enc_last, out_full,
      input  enc_stall, out_wrreq, out_data, out_stream, out_last, blk_done
   );
endinterface

// File: rtl/conv_out_packer.sv
// Packs the three encoder streams into bytes and writes them as interleaved 3-byte groups.
// Bit order is LSB-first by default; define PACK_MSB_FIRST_EN for MSB-first packing.
module conv_out_packer #(
   parameter int GRP_DEPTH = 2
) (
   input logic               clk,
   input logic               reset,
   conv_out_packer_if.master bus
);
   typedef struct packed {
      logic            last;
      logic [2:0][7:0] b;
   } grp_t;

   typedef enum logic [1:0] {IDLE, E0, E1, E2} state_t;

   state_t          state;
   logic [2:0]      bcnt;
   logic [2:0][7:0] sr;
   grp_t            grp_buf [GRP_DEPTH];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      count;
   logic            blk_done_q;

   logic            accept, grp_done, push, pop, wr_en;
   logic [2:0]      pos;
   logic [2:0][7:0] sr_nxt;
   logic [1:0]      cnt_after;
   grp_t            head;

   assign bus.enc_stall = (count == 2'd2);
   assign accept        = bus.enc_valid && !bus.enc_stall;
   assign grp_done      = (bcnt == 3'd7) || bus.enc_last;
   assign push          = accept && grp_done;

`ifdef PACK_MSB_FIRST_EN
   assign pos = 3'd7 - bcnt;
`else
   assign pos = bcnt;
`endif

   // First bit of a group starts from a zeroed byte, so partial groups come out padded.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sr_nxt[i]      = (bcnt == 3'd0) ? 8'h00 : sr[i];
         sr_nxt[i][pos] = bus.enc_d[i];
      end
   end

   assign head      = grp_buf[rd_ptr];
   assign wr_en     = (state != IDLE) && !bus.out_full;
   assign pop       = wr_en && (state == E2);
   assign cnt_after = count - 2'(pop) + 2'(push);
   assign bus.blk_done = blk_done_q;

   always_comb begin
      bus.out_wrreq  = wr_en;
      bus.out_data   = 8'h00;
      bus.out_stream = 2'd0;
      bus.out_last   = 1'b0;
      if (wr_en) begin
         case (state)
            E0: begin bus.out_data = head.b[0]; bus.out_stream = 2'd0; end
            E1: begin bus.out_data = head.b[1]; bus.out_stream = 2'd1; end
            E2: begin
               bus.out_data   = head.b[2];
               bus.out_stream = 2'd2;
               bus.out_last   = head.last;
            end
            default: ;
         endcase
      end
   end

   // Group storage carries no reset; count and pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (push) grp_buf[wr_ptr] <= {bus.enc_last, sr_nxt};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bcnt       <= 3'd0;
         sr         <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         blk_done_q <= 1'b0;
      end else begin
         blk_done_q <= pop && head.last;
         count      <= cnt_after;
         if (accept) begin
            sr   <= sr_nxt;
            bcnt <= grp_done ? 3'd0 : bcnt + 3'd1;
         end
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case (state)
            IDLE: if (count != 2'd0) state <= E0;
            E0:   if (wr_en) state <= E1;
            E1:   if (wr_en) state <= E2;
            E2:   if (wr_en) state <= (cnt_after != 2'd0) ? E0 : IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_out_packer.sv
// Scoreboard bench for conv_out_packer: a bit-list model predicts every byte write.
module tb_conv_out_packer;
`ifdef PACK_MSB_FIRST_EN
   localparam bit MSB = 1'b1;
`else
   localparam bit MSB = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic [1:0] stream;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   conv_out_packer_if bus();

   conv_out_packer #(.GRP_DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   int   n_wr = 0;
   int   n_last = 0;
   int   full_mode = 1;
   exp_t exp_q[$];
   logic [7:0] log0[$];
   logic bits [3][8];
   int   nb = 0;
   logic prev_wr_last = 1'b0;
   exp_t e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: collect bits per stream, emit a 3-byte group on 8 bits or on last.
   task automatic model_accept(input logic [2:0] d, input logic last);
      int v;
      for (int i = 0; i < 3; i++) bits[i][nb] = d[i];
      nb++;
      if (nb == 8 || last) begin
         for (int i = 0; i < 3; i++) begin
            v = 0;
            for (int j = 0; j < nb; j++)
               if (bits[i][j]) v += MSB ? (1 << (7 - j)) : (1 << j);
            exp_q.push_back('{data: 8'(v), stream: 2'(i), last: last && (i == 2)});
         end
         nb = 0;
      end
   endtask

   task automatic send(input logic [2:0] d, input logic last);
      int w = 0;
      @(negedge clk);
      bus.enc_valid = 1'b1;
      bus.enc_d     = d;
      bus.enc_last  = last;
      while (bus.enc_stall && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (bus.enc_stall) begin
         n_chk++;
         n_fail++;
         $display("FAIL stall_timeout: enc_stall still high after %0d cycles", w);
      end else begin
         model_accept(d, last);
      end
      @(posedge clk);
      #1 bus.enc_valid = 1'b0;
      bus.enc_last = 1'b0;
   endtask

   task automatic send_block(input int len, input int pat);
      logic [2:0] d;
      for (int k = 0; k < len; k++) begin
         case (pat)
            0:       d = 3'b101;
            1:       d = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, (k % 2) == 0};
            default: d = 3'($urandom_range(0, 7));
         endcase
         send(d, k == len - 1);
         if (pat == 3 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic drain(input string name);
      int w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      case (full_mode)
         0:       bus.out_full = 1'b0;
         1:       bus.out_full = 1'b1;
         2:       bus.out_full = ~bus.out_full;
         default: bus.out_full = ($urandom_range(0, 3) == 0);
      endcase
   end

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      check("blk_done", bus.blk_done, prev_wr_last);
      prev_wr_last = bus.out_wrreq && bus.out_last;
      if (bus.out_wrreq) begin
         n_wr++;
         if (bus.out_last) n_last++;
         if (bus.out_stream == 2'd0) log0.push_back(bus.out_data);
         check("wr_while_full", bus.out_full, 1'b0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got data %0h stream %0d, required no write",
                     bus.out_data, bus.out_stream);
         end else begin
            e = exp_q.pop_front();
            check("out_data",   bus.out_data,   e.data);
            check("out_stream", bus.out_stream, e.stream);
            check("out_last",   bus.out_last,   e.last);
         end
      end else begin
         check("idle_outputs", {bus.out_data, bus.out_stream, bus.out_last}, 0);
      end
   end

   initial begin
      int   wr0, last0, w;
      logic stall_seen;
      bus.enc_valid = 1'b0;
      bus.enc_d     = 3'd0;
      bus.enc_last  = 1'b0;
      bus.out_full  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wrreq", bus.out_wrreq, 1'b0);
      check("rst_stall", bus.enc_stall, 1'b0);
      check("rst_blk_done", bus.blk_done, 1'b0);
      reset = 1'b0;
      full_mode = 0;
      repeat (2) @(negedge clk);

      // 40 bits of 3'b101: five groups FF/00/FF
      wr0 = n_wr; last0 = n_last;
      send_block(40, 0);
      drain("drain_40bit");
      check("writes_40bit", n_wr - wr0, 15);
      check("lasts_40bit", n_last - last0, 1);

      // single-sample block
      wr0 = n_wr;
      send(3'b011, 1'b1);
      drain("drain_single");
      check("writes_single", n_wr - wr0, 3);

      // 12-bit block, stream 0 alternating starting with 1
      log0.delete();
      send_block(12, 1);
      drain("drain_12bit");
      check("s0_bytes", log0.size(), 2);
      if (log0.size() == 2) begin
         check("s0_byte0", log0[0], MSB ? 8'hAA : 8'h55);
         check("s0_byte1", log0[1], MSB ? 8'hA0 : 8'h05);
      end

      // 64-bit block with out_full high for 30 cycles
      full_mode = 1;
      repeat (2) @(negedge clk);
      stall_seen = 1'b0;
      wr0 = n_wr;
      fork
         send_block(64, 2);
         begin
            repeat (30) begin
               @(negedge clk);
               if (bus.enc_stall) stall_seen = 1'b1;
            end
            check("writes_while_full", n_wr - wr0, 0);
            full_mode = 0;
         end
      join
      drain("drain_64bit");
      check("stall_seen", stall_seen, 1'b1);
      check("writes_64bit", n_wr - wr0, 24);

      // reset while the emitter holds in E1 of a 48-bit block
      full_mode = 1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 16; k++) send(3'($urandom_range(0, 7)), 1'b0);
      @(negedge clk);
      check("stall_two_groups", bus.enc_stall, 1'b1);
      wr0 = n_wr;
      full_mode = 0;
      w = 0;
      while (n_wr == wr0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      full_mode = 1;
      check("e0_written", n_wr - wr0, 1);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      nb = 0;
      @(negedge clk);
      check("rst_mid_wrreq", bus.out_wrreq, 1'b0);
      check("rst_mid_stall", bus.enc_stall, 1'b0);
      reset = 1'b0;
      full_mode = 0;
      wr0 = n_wr;
      repeat (10) @(negedge clk);
      check("no_writes_after_rst", n_wr - wr0, 0);
      send_block(8, 2);
      drain("drain_post_rst");
      check("writes_post_rst", n_wr - wr0, 3);

      // out_full toggling under continuous input
      full_mode = 2;
      send_block(64, 2);
      drain("drain_toggle");

      // random blocks, random backpressure and gaps
      full_mode = 3;
      for (int b = 0; b < 5; b++) send_block($urandom_range(1, 40), 3);
      full_mode = 0;
      drain("drain_random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
